// File: rtl/riscv_pkg.sv
// ============================================================================
// Module  : riscv_pkg
// Brief   : Shared constants and fetch-state encoding for the fetch front end.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

  localparam int          XLEN             = 32;
  localparam int          IMEM_ADDR_W      = 6;
  localparam int          PC_STEP          = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [0:0] {
    FETCH_RUN  = 1'b0,
    FETCH_SKID = 1'b1
  } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/fetch_skid_buffer.sv
// ============================================================================
// Module  : fetch_skid_buffer
// Brief   : One-entry holding register for an instruction refused by decode.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_skid_buffer #(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            clear,
  input  logic [XLEN-1:0] data_in,
  input  logic [XLEN-1:0] pc_in,
  output logic            valid,
  output logic [XLEN-1:0] data,
  output logic [XLEN-1:0] pc
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] data_q,  data_d;
  logic [XLEN-1:0] pc_q,    pc_d;

  // Clear wins over load so a redirect always empties the entry.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    pc_d    = pc_q;
    if (clear) begin
      valid_d = 1'b0;
      data_d  = '0;
      pc_d    = '0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = data_in;
      pc_d    = pc_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      pc_q    <= pc_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign pc    = pc_q;

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
// ============================================================================
// Module  : instr_fetch
// Brief   : Fetch stage driving a 1-cycle-latency instruction memory, with a
//           one-entry skid for decode back-pressure and branch redirect.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch #(
  parameter logic [31:0] RESET_PC    = riscv_pkg::RESET_PC_DEFAULT,
  parameter int          IMEM_ADDR_W = riscv_pkg::IMEM_ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [IMEM_ADDR_W-1:0] mem_adr,
  input  logic [31:0]            mem_rd,
  input  logic                   branch_taken,
  input  logic [31:0]            branch_target,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_instr,
  output logic [31:0]            out_pc
);

  import riscv_pkg::*;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_issue_q, pc_issue_d;
  logic [XLEN-1:0] pc_resp_q, pc_resp_d;
  logic            resp_valid_q, resp_valid_d;

  logic            skid_load;
  logic            skid_clear;
  logic            skid_valid;
  logic [XLEN-1:0] skid_data;
  logic [XLEN-1:0] skid_pc;

  // Redirect targets are word aligned; the low bits are intentionally dropped.
  logic unused_target_lsbs;
  assign unused_target_lsbs = ^branch_target[1:0];

  fetch_skid_buffer #(
    .XLEN(XLEN)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load    (skid_load),
    .clear   (skid_clear),
    .data_in (mem_rd),
    .pc_in   (pc_resp_q),
    .valid   (skid_valid),
    .data    (skid_data),
    .pc      (skid_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH_RUN;
      pc_issue_q   <= RESET_PC;
      pc_resp_q    <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_issue_q   <= pc_issue_d;
      pc_resp_q    <= pc_resp_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_issue_d   = pc_issue_q;
    pc_resp_d    = pc_resp_q;
    resp_valid_d = resp_valid_q;
    skid_load    = 1'b0;
    skid_clear   = 1'b0;
    if (branch_taken) begin
      pc_issue_d   = {branch_target[31:2], 2'b00};
      resp_valid_d = 1'b0;
      skid_clear   = 1'b1;
      state_d      = FETCH_RUN;
    end else begin
      case (state_q)
        FETCH_RUN: begin
          if (!resp_valid_q || out_ready) begin
            pc_resp_d    = pc_issue_q;
            pc_issue_d   = pc_issue_q + XLEN'(PC_STEP);
            resp_valid_d = 1'b1;
          end else begin
            // The memory word is gone next cycle, so park it in the skid.
            skid_load    = 1'b1;
            resp_valid_d = 1'b0;
            state_d      = FETCH_SKID;
          end
        end
        FETCH_SKID: begin
          if (out_ready) begin
            pc_resp_d    = pc_issue_q;
            pc_issue_d   = pc_issue_q + XLEN'(PC_STEP);
            resp_valid_d = 1'b1;
            skid_clear   = 1'b1;
            state_d      = FETCH_RUN;
          end
        end
        default: state_d = FETCH_RUN;
      endcase
    end
  end

  always_comb begin
    out_valid = 1'b0;
    out_instr = '0;
    out_pc    = '0;
    if (!rst) begin
      case (state_q)
        FETCH_RUN: begin
          out_valid = resp_valid_q & ~branch_taken;
          out_pc    = pc_resp_q;
          if (resp_valid_q) out_instr = mem_rd;
        end
        FETCH_SKID: begin
          out_valid = skid_valid & ~branch_taken;
          out_instr = skid_data;
          out_pc    = skid_pc;
        end
        default: out_valid = 1'b0;
      endcase
    end
  end

  assign mem_adr = pc_issue_q[IMEM_ADDR_W+1:2];

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ============================================================================
// Module  : tb_instr_fetch
// Brief   : Directed self-checking bench for instr_fetch with a 64x32 memory.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  mem_adr;
  logic [31:0] mem_rd;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  logic [31:0] mem [64];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) mem_rd <= mem[mem_adr];

  instr_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .mem_adr       (mem_adr),
    .mem_rd        (mem_rd),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_word(input string name, input logic [31:0] pc, input logic [31:0] instr);
    checks++;
    if (out_valid !== 1'b1 || out_pc !== pc || out_instr !== instr) begin
      errors++;
      $display("FAIL %s got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h",
               name, out_valid, out_pc, out_instr, pc, instr);
    end
  endtask

  task automatic expect_idle(input string name);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s got out_valid=%b want 0 (pc=%h)", name, out_valid, out_pc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; out_ready = 1'b1; branch_taken = 1'b0; branch_target = '0;
    tick(); tick();
    checks++;
    if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'h0 || mem_adr !== 6'd0) begin
      errors++;
      $display("FAIL reset_state got v=%b pc=%h instr=%h adr=%0d want 0 0 0 0",
               out_valid, out_pc, out_instr, mem_adr);
    end
    rst = 1'b0;
    expect_idle("reset_release_cycle1");
    tick();
  endtask

  task automatic test_stream();
    for (int i = 0; i < 2; i++) begin
      expect_word("stream", 32'(4 * i), 32'h1000_0000 + 32'(i));
      tick();
    end
  endtask

  task automatic test_stall();
    expect_word("stall_before", 32'h8, 32'h1000_0002);
    out_ready = 1'b0;
    tick();
    expect_word("stall_hold1", 32'h8, 32'h1000_0002);
    tick();
    expect_word("stall_hold2", 32'h8, 32'h1000_0002);
    out_ready = 1'b1;
    tick();
    expect_word("stall_resume", 32'hC, 32'h1000_0003);
    tick();
    expect_word("stall_next", 32'h10, 32'h1000_0004);
  endtask

  task automatic test_branch();
    branch_taken = 1'b1; branch_target = 32'h0000_0022;
    #1;
    expect_idle("branch_cycle");
    tick();
    branch_taken = 1'b0;
    expect_idle("branch_bubble");
    tick();
    expect_word("branch_target", 32'h20, 32'h1000_0008);
    tick();
    expect_word("branch_follow", 32'h24, 32'h1000_0009);
  endtask

  task automatic test_branch_in_skid();
    out_ready = 1'b0;
    tick();
    expect_word("skid_held", 32'h24, 32'h1000_0009);
    branch_taken = 1'b1; branch_target = 32'h0000_0040;
    #1;
    expect_idle("skid_branch_cycle");
    tick();
    branch_taken = 1'b0; out_ready = 1'b1;
    expect_idle("skid_branch_bubble");
    tick();
    expect_word("skid_branch_target", 32'h40, 32'h1000_0010);
    tick();
    expect_word("skid_branch_follow", 32'h44, 32'h1000_0011);
  endtask

  task automatic test_back_to_back_branch();
    out_ready = 1'b0;
    branch_taken = 1'b1; branch_target = 32'h0000_0080;
    tick();
    branch_target = 32'h0000_00C3;
    out_ready = 1'b1;
    tick();
    branch_taken = 1'b0;
    expect_idle("b2b_bubble");
    tick();
    expect_word("b2b_last_wins", 32'hC0, 32'h1000_0030);
  endtask

  task automatic test_wrap();
    branch_taken = 1'b1; branch_target = 32'h0000_00F8;
    tick();
    branch_taken = 1'b0;
    tick();
    expect_word("wrap_f8", 32'hF8, 32'h1000_003E);
    checks++;
    if (mem_adr !== 6'd63) begin
      errors++;
      $display("FAIL wrap_adr63 got %0d want 63", mem_adr);
    end
    tick();
    expect_word("wrap_fc", 32'hFC, 32'h1000_003F);
    checks++;
    if (mem_adr !== 6'd0) begin
      errors++;
      $display("FAIL wrap_adr0 got %0d want 0", mem_adr);
    end
    tick();
    expect_word("wrap_100", 32'h100, 32'h1000_0000);
  endtask

  task automatic test_reset_during_stall();
    out_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    expect_idle("rst_stall_idle");
    rst = 1'b0; out_ready = 1'b1;
    tick();
    expect_word("rst_restart", 32'h0, 32'h1000_0000);
    tick();
    expect_word("rst_restart_next", 32'h4, 32'h1000_0001);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + 32'(i);
    test_reset();
    test_stream();
    test_stall();
    test_branch();
    test_branch_in_skid();
    test_back_to_back_branch();
    test_wrap();
    test_reset_during_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
